output_port_tx: RTL and testbench

OUTPUT_PORT_TX -- requirements
Module: output_port_tx

---
 rtl/output_port_tx_pkg.sv | 31 +++
 rtl/output_port_tx_rr_arbiter.sv | 25 ++
 rtl/output_port_tx.sv | 126 ++++++++++++
 tb/tb_output_port_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/output_port_tx_pkg.sv
// Shared flit/credit word layout and sizing constants for the router.
package output_port_tx_pkg;
  localparam int MAX_VC   = 32;
  localparam int CRBUF_SZ = 8;
  localparam int FLIT_W   = 22;
  localparam int VLD_BIT  = 21;
  localparam int VC_HI    = 20;
  localparam int VC_LO    = 16;
  localparam int VC_W     = $clog2(MAX_VC);
  localparam int PAY_W    = 16;

  // Same layout carries flits (data = payload) and credits (data = issue cycle).
  typedef struct packed {
    logic             vld;
    logic [VC_W-1:0]  vc;
    logic [PAY_W-1:0] data;
  } flit_t;

  typedef struct packed {
    logic [VC_W-1:0]  vc;
    logic [PAY_W-1:0] due;
  } crq_ent_t;

  // Wrap-safe "cycle has reached due": signed 16-bit difference is non-negative.
  function automatic logic credit_ripe(input logic [PAY_W-1:0] now,
                                       input logic [PAY_W-1:0] due);
    logic [PAY_W-1:0] diff;
    diff = now - due;
    return !diff[PAY_W-1];
  endfunction
endpackage

// File: rtl/output_port_tx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after ptr.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_tx.sv
// Router output port: per-VC flit FIFOs, delayed credit return queue,
// credit-gated round-robin issue onto a registered output flit.
module output_port_tx
  import output_port_tx_pkg::*;
#(
  parameter int NUM_VC      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_INIT = 1,
  parameter int CRQ_DEPTH   = CRBUF_SZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [NUM_VC-1:0] in_ready,
  output logic [FLIT_W-1:0] out_flit,
  input  logic [FLIT_W-1:0] cr_in,
  input  logic [PAY_W-1:0]  cycle,
  input  logic [PAY_W-1:0]  credit_delay,
  output logic              idle,
  output logic [2:0]        err
);
  localparam int VW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int QAW = (CRQ_DEPTH > 1) ? $clog2(CRQ_DEPTH) : 1;
  localparam int QCW = $clog2(CRQ_DEPTH + 1);

  flit_t fin, cin, out_q;
  assign fin      = flit_t'(in_flit);
  assign cin      = flit_t'(cr_in);
  assign out_flit = out_q;

  logic [NUM_VC-1:0][FIFO_DEPTH-1:0][PAY_W-1:0] fifo_mem;
  logic [NUM_VC-1:0][FAW-1:0] f_head, f_tail;
  logic [NUM_VC-1:0][FCW-1:0] f_cnt;
  logic [NUM_VC-1:0][7:0]     credit;

  crq_ent_t [CRQ_DEPTH-1:0] crq_mem;
  logic [QAW-1:0] q_head, q_tail;
  logic [QCW-1:0] q_cnt;
  logic [VW-1:0]  rr_ptr;

  logic [NUM_VC-1:0] elig, gnt, wr_en, cr_inc, sat;
  logic              q_push, q_pop, f_drop, q_drop;
  crq_ent_t          q_head_ent;
  logic [VW-1:0]     gnt_vc;
  logic [PAY_W-1:0]  gnt_data;

  always_comb begin
    in_ready = '0;
    elig     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      in_ready[v] = (f_cnt[v] != FCW'(FIFO_DEPTH));
      elig[v]     = (f_cnt[v] != '0) && (credit[v] != 8'd0);
    end
    idle = (f_cnt == '0) && (q_cnt == '0);
  end

  rr_arbiter #(.N(NUM_VC)) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_vc     = '0;
    gnt_data   = '0;
    wr_en      = '0;
    cr_inc     = '0;
    sat        = '0;
    q_head_ent = crq_mem[q_head];
    q_pop      = (q_cnt != '0) && credit_ripe(cycle, q_head_ent.due);
    q_push     = cin.vld && (q_cnt != QCW'(CRQ_DEPTH));
    q_drop     = cin.vld && !q_push;
    for (int v = 0; v < NUM_VC; v++) begin
      if (gnt[v]) begin
        gnt_vc   = VW'(v);
        gnt_data = fifo_mem[v][f_head[v]];
      end
      // A full FIFO still takes the new flit when its head leaves this cycle.
      wr_en[v]  = fin.vld && (fin.vc == VC_W'(v)) && (in_ready[v] || gnt[v]);
      cr_inc[v] = q_pop && (q_head_ent.vc == VC_W'(v));
      sat[v]    = cr_inc[v] && !gnt[v] && (credit[v] == 8'hFF);
    end
    // Covers both a full target FIFO and a vc beyond NUM_VC.
    f_drop = fin.vld && (wr_en == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      f_head <= '0;
      f_tail <= '0;
      f_cnt  <= '0;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= 8'(CREDIT_INIT);
      q_head <= '0;
      q_tail <= '0;
      q_cnt  <= '0;
      rr_ptr <= VW'(NUM_VC - 1);
      err    <= '0;
    end else begin
      out_q <= (gnt != '0) ? flit_t'{vld: 1'b1, vc: VC_W'(gnt_vc), data: gnt_data} : '0;
      if (gnt != '0) rr_ptr <= gnt_vc;
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_en[v])
          f_tail[v] <= (f_tail[v] == FAW'(FIFO_DEPTH - 1)) ? '0 : f_tail[v] + 1'b1;
        if (gnt[v])
          f_head[v] <= (f_head[v] == FAW'(FIFO_DEPTH - 1)) ? '0 : f_head[v] + 1'b1;
        f_cnt[v] <= f_cnt[v] + FCW'(wr_en[v]) - FCW'(gnt[v]);
        if (cr_inc[v] && !gnt[v] && !sat[v]) credit[v] <= credit[v] + 8'd1;
        else if (gnt[v] && !cr_inc[v])       credit[v] <= credit[v] - 8'd1;
      end
      if (q_push) q_tail <= (q_tail == QAW'(CRQ_DEPTH - 1)) ? '0 : q_tail + 1'b1;
      if (q_pop)  q_head <= (q_head == QAW'(CRQ_DEPTH - 1)) ? '0 : q_head + 1'b1;
      q_cnt <= q_cnt + QCW'(q_push) - QCW'(q_pop);
      err   <= err | {(sat != '0), q_drop, f_drop};
    end
  end

  // Storage is not reset; validity is tracked solely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (wr_en[v]) fifo_mem[v][f_tail[v]] <= fin.data;
    if (q_push) crq_mem[q_tail] <= crq_ent_t'{vc: cin.vc, due: cin.data + credit_delay};
  end
endmodule

// File: tb/tb_output_port_tx.sv
// Directed vector bench for output_port_tx with default parameters.
module tb_output_port_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] in_flit = '0;
  logic [21:0] cr_in = '0;
  logic [15:0] cycle = '0;
  logic [15:0] credit_delay = '0;
  logic [3:0]  in_ready;
  logic [21:0] out_flit;
  logic        idle;
  logic [2:0]  err;

  output_port_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .out_flit     (out_flit),
    .cr_in        (cr_in),
    .cycle        (cycle),
    .credit_delay (credit_delay),
    .idle         (idle),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [21:0] fl;
    logic [21:0] cr;
    logic [15:0] cyc;
    logic [15:0] dly;
    logic [21:0] e_out;
    logic [3:0]  e_rdy;
    logic        e_idle;
    logic [2:0]  e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [21:0] Z = 22'h0;
  localparam logic [3:0]  R = 4'hF;

  function automatic logic [21:0] f(input int vc, input int pay);
    return {1'b1, 5'(vc), 16'(pay)};
  endfunction

  task automatic add(input logic r, input logic [21:0] fl, input logic [21:0] cr,
                     input logic [15:0] cyc, input logic [15:0] dly,
                     input logic [21:0] eo, input logic [3:0] er,
                     input logic ei, input logic [2:0] ee);
    vec_t v;
    v.rst_n = r; v.fl = fl; v.cr = cr; v.cyc = cyc; v.dly = dly;
    v.e_out = eo; v.e_rdy = er; v.e_idle = ei; v.e_err = ee;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst_n = v.rst_n; in_flit = v.fl; cr_in = v.cr;
    cycle = v.cyc; credit_delay = v.dly;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_flit !== v.e_out || in_ready !== v.e_rdy || idle !== v.e_idle || err !== v.e_err) begin
      n_miss++;
      $display("FAIL %s: got out=%h rdy=%h idle=%b err=%b, expected out=%h rdy=%h idle=%b err=%b",
               tag, out_flit, in_ready, idle, err, v.e_out, v.e_rdy, v.e_idle, v.e_err);
    end
  endtask

  task automatic run(input logic r, input logic [21:0] fl, input logic [21:0] cr,
                     input logic [21:0] eo, input logic [3:0] er,
                     input logic ei, input logic [2:0] ee, input string tag);
    vec_t v;
    v.rst_n = r; v.fl = fl; v.cr = cr; v.cyc = 16'd100; v.dly = 16'd0;
    v.e_out = eo; v.e_rdy = er; v.e_idle = ei; v.e_err = ee;
    apply(v, tag);
  endtask

  initial begin
    // A: first-flit latency, credit-held second flit, delayed credit return, bad vc
    add(0, f(2,'h11),   f(2,0),  0, 3, Z,         R, 1, 0);
    add(1, f(2,'hAB),   Z,       1, 3, Z,         R, 0, 0);
    add(1, f(2,'hCD),   Z,       2, 3, 22'h2200AB, R, 0, 0);
    add(1, Z,           Z,       3, 3, Z,         R, 0, 0);
    add(1, Z,           f(2,10), 10, 3, Z,        R, 0, 0);
    add(1, Z,           Z,       11, 3, Z,        R, 0, 0);
    add(1, Z,           Z,       12, 3, Z,        R, 0, 0);
    add(1, Z,           Z,       13, 3, Z,        R, 0, 0);
    add(1, Z,           Z,       14, 3, 22'h2200CD, R, 1, 0);
    add(1, f(5,'h5555), Z,       15, 3, Z,        R, 1, 1);
    add(1, Z,           Z,       16, 3, Z,        R, 1, 1);
    // B: due wraps past 0xFFFF
    add(0, Z,             Z,             'h0000, 4, Z,          R, 1, 0);
    add(1, f(2,'h1111),   Z,             'hFFF0, 4, Z,          R, 0, 0);
    add(1, f(2,'h2222),   Z,             'hFFF1, 4, 22'h221111, R, 0, 0);
    add(1, Z,             f(2,'hFFFE),   'hFFFE, 4, Z,          R, 0, 0);
    add(1, Z,             Z,             'hFFFF, 4, Z,          R, 0, 0);
    add(1, Z,             Z,             'h0000, 4, Z,          R, 0, 0);
    add(1, Z,             Z,             'h0001, 4, Z,          R, 0, 0);
    add(1, Z,             Z,             'h0002, 4, Z,          R, 0, 0);
    add(1, Z,             Z,             'h0003, 4, 22'h222222, R, 1, 0);
    // C: round robin across VCs 0,1,3 with two or more eligible at once
    add(0, Z,           Z,         100, 0, Z,          R, 1, 0);
    add(1, f(0,'hA000), Z,         100, 0, Z,          R, 0, 0);
    add(1, f(1,'hA001), Z,         100, 0, 22'h20A000, R, 0, 0);
    add(1, f(3,'hA003), Z,         100, 0, 22'h21A001, R, 0, 0);
    add(1, f(0,'hB000), f(3,100),  100, 0, 22'h23A003, R, 0, 0);
    add(1, f(0,'hB001), f(3,100),  100, 0, Z,          R, 0, 0);
    add(1, f(1,'hC000), Z,         100, 0, Z,          R, 0, 0);
    add(1, f(1,'hC001), Z,         100, 0, Z,          R, 0, 0);
    add(1, Z,           f(0,100),  100, 0, Z,          R, 0, 0);
    add(1, f(3,'hD003), f(1,100),  100, 0, Z,          R, 0, 0);
    add(1, Z,           f(0,100),  100, 0, 22'h20B000, R, 0, 0);
    add(1, Z,           f(1,100),  100, 0, 22'h21C000, R, 0, 0);
    add(1, Z,           Z,         100, 0, 22'h23D003, R, 0, 0);
    add(1, Z,           Z,         100, 0, 22'h20B001, R, 0, 0);
    add(1, Z,           Z,         100, 0, 22'h21C001, R, 1, 0);
    add(1, Z,           Z,         100, 0, Z,          R, 1, 0);
    // D: overflow VC 1 (no credit), then drain the first two in order
    add(1, f(1,'hE000), Z,        100, 0, Z,          R,     0, 0);
    add(1, f(1,'hE001), Z,        100, 0, Z,          R,     0, 0);
    add(1, f(1,'hE002), Z,        100, 0, Z,          R,     0, 0);
    add(1, f(1,'hE003), Z,        100, 0, Z,          4'hD,  0, 0);
    add(1, f(1,'hE004), Z,        100, 0, Z,          4'hD,  0, 1);
    add(1, Z,           f(1,100), 100, 0, Z,          4'hD,  0, 1);
    add(1, Z,           Z,        100, 0, Z,          4'hD,  0, 1);
    add(1, Z,           f(1,100), 100, 0, 22'h21E000, R,     0, 1);
    add(1, Z,           Z,        100, 0, Z,          R,     0, 1);
    add(1, Z,           Z,        100, 0, 22'h21E001, R,     0, 1);
    // E: reset with flits and a credit pending
    add(1, Z,           f(1,100), 100, 50, Z,          R, 0, 1);
    add(0, f(1,'h7777), f(1,100), 200, 0,  Z,          R, 1, 0);
    add(1, Z,           Z,        200, 0,  Z,          R, 1, 0);
    add(1, f(1,'hF001), Z,        201, 0,  Z,          R, 0, 0);
    add(1, f(1,'hF011), Z,        202, 0,  22'h21F001, R, 0, 0);
    add(1, Z,           Z,        203, 0,  Z,          R, 0, 0);
    add(1, Z,           Z,        204, 0,  Z,          R, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Full FIFO accepts a flit in the same cycle its head is granted.
    run(0, Z,           Z,        Z,          R,    1, 0, "fullpop0");
    run(1, f(0,'h0010), Z,        Z,          R,    0, 0, "fullpop1");
    run(1, f(0,'h0020), Z,        22'h200010, R,    0, 0, "fullpop2");
    run(1, f(0,'h0021), Z,        Z,          R,    0, 0, "fullpop3");
    run(1, f(0,'h0022), Z,        Z,          R,    0, 0, "fullpop4");
    run(1, f(0,'h0023), Z,        Z,          4'hE, 0, 0, "fullpop5");
    run(1, Z,           f(0,100), Z,          4'hE, 0, 0, "fullpop6");
    run(1, Z,           Z,        Z,          4'hE, 0, 0, "fullpop7");
    run(1, f(0,'h0024), Z,        22'h200020, 4'hE, 0, 0, "fullpop8");
    run(1, Z,           Z,        Z,          4'hE, 0, 0, "fullpop9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
